// File: rtl/config_pkg.sv
// Shared widths, default sizing and helpers for the configuration width buffer.
package config_pkg;

  localparam int unsigned CFG_DIN_W            = 64;
  localparam int unsigned CFG_DOUT_W           = 32;
  localparam int unsigned CFG_DEPTH            = 1024;
  localparam int unsigned CFG_PROG_FULL_THRESH = 512;

  typedef logic [CFG_DIN_W-1:0]  cfg_beat_t;
  typedef logic [CFG_DOUT_W-1:0] cfg_word_t;

  // Width of the 32-bit word count output for a given depth in 64-bit entries.
  function automatic int unsigned cfg_count_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/config_width_buffer_if.sv
// Write/read bus between the DMA receive path (master) and the width buffer (slave).
interface config_width_buffer_if #(
  parameter int unsigned DEPTH = config_pkg::CFG_DEPTH
);
  import config_pkg::*;

  localparam int unsigned CountW = cfg_count_w(DEPTH);

  cfg_beat_t         i_din;
  logic              i_wr_en;
  logic              i_rd_en;
  cfg_word_t         o_dout;
  logic              o_full;
  logic              o_empty;
  logic              o_prog_full;
  logic [CountW-1:0] o_rd_data_count;

  modport master (
    output i_din, i_wr_en, i_rd_en,
    input  o_dout, o_full, o_empty, o_prog_full, o_rd_data_count
  );

  modport slave (
    input  i_din, i_wr_en, i_rd_en,
    output o_dout, o_full, o_empty, o_prog_full, o_rd_data_count
  );

endinterface

// File: rtl/config_buffer_ram.sv
// Simple dual-port RAM, DEPTH x 64, synchronous write and registered synchronous read.
module config_buffer_ram
  import config_pkg::*;
#(
  parameter int unsigned DEPTH  = CFG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  cfg_beat_t         i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output cfg_beat_t         o_rd_data
);

  cfg_beat_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register is reset so the output word is zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/config_width_buffer.sv
// 64-to-32 bit FIFO between PCIe DMA receive and the ICAP feeder; upper half is read first.
module config_width_buffer
  import config_pkg::*;
#(
  parameter int unsigned DEPTH            = CFG_DEPTH,
  parameter int unsigned PROG_FULL_THRESH = CFG_PROG_FULL_THRESH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  config_width_buffer_if.slave bus
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned RdPtrW = AddrW + 1;
  localparam int unsigned CntW   = AddrW + 2;
  localparam int unsigned CountW = cfg_count_w(DEPTH);

  localparam logic [CntW-1:0] FullAbove  = CntW'(2 * DEPTH - 2);
  localparam logic [CntW-1:0] ProgFullAt = CntW'(2 * PROG_FULL_THRESH);

  logic [AddrW-1:0]  wr_ptr_q;
  logic [RdPtrW-1:0] rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CountW-1:0] count_q, count_d;
  logic              full_q, empty_q, prog_full_q;
  logic              half_sel_q;
  logic              wr_accept, rd_accept;
  cfg_beat_t         rd_beat;

  // Acceptance looks only at the registered flags from before the edge.
  assign wr_accept = bus.i_wr_en & ~full_q;
  assign rd_accept = bus.i_rd_en & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_accept, rd_accept})
      2'b10:   cnt_d = cnt_q + CntW'(2);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      2'b11:   cnt_d = cnt_q + CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Only a completely full buffer sets the top bit; clamp to all-ones on the narrower port.
    count_d = cnt_d[CntW-1] ? '1 : cnt_d[CountW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      prog_full_q <= 1'b0;
      half_sel_q  <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (rd_accept) begin
        rd_ptr_q   <= rd_ptr_q + RdPtrW'(1);
        half_sel_q <= rd_ptr_q[0];
      end
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      empty_q     <= (cnt_d == '0);
      full_q      <= (cnt_d > FullAbove);
      prog_full_q <= (cnt_d >= ProgFullAt);
    end
  end

  config_buffer_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AddrW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (wr_accept),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (bus.i_din),
    .i_rd_en   (rd_accept),
    .i_rd_addr (rd_ptr_q[RdPtrW-1:1]),
    .o_rd_data (rd_beat)
  );

  assign bus.o_dout          = half_sel_q ? rd_beat[CFG_DOUT_W-1:0]
                                          : rd_beat[CFG_DIN_W-1:CFG_DOUT_W];
  assign bus.o_full          = full_q;
  assign bus.o_empty         = empty_q;
  assign bus.o_prog_full     = prog_full_q;
  assign bus.o_rd_data_count = count_q;

endmodule

// File: tb/tb_config_width_buffer.sv
// Directed bench for config_width_buffer: vector table plus multi-cycle corner sequences.
module tb_config_width_buffer;

  localparam int unsigned Depth  = 1024;
  localparam int unsigned Thresh = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  config_width_buffer_if #(.DEPTH(Depth)) bus ();

  config_width_buffer #(
    .DEPTH            (Depth),
    .PROG_FULL_THRESH (Thresh)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [63:0] din;
    logic [31:0] dout;
    logic        empty;
    logic        full;
    logic        pf;
    logic [10:0] count;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_flags(input string tag, input logic empty, input logic full,
                             input logic pf, input logic [10:0] count);
    check({tag, ".empty"}, 64'(bus.o_empty), 64'(empty));
    check({tag, ".full"}, 64'(bus.o_full), 64'(full));
    check({tag, ".prog_full"}, 64'(bus.o_prog_full), 64'(pf));
    check({tag, ".count"}, 64'(bus.o_rd_data_count), 64'(count));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_din   = '0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] beat(input int unsigned tag, input int unsigned i);
    logic [31:0] hi;
    hi = 32'hB000_0000 + (32'(tag) << 16) + 32'(i);
    return {hi, ~hi};
  endfunction

  logic [31:0] q [$];
  logic [31:0] exp_word;
  logic [63:0] b;

  initial begin
    // wr, rd, din, expected dout, empty, full, prog_full, count (after the edge)
    vecs[0] = '{1'b0, 1'b1, 64'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 11'd0};
    vecs[1] = '{1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd2};
    vecs[2] = '{1'b0, 1'b1, 64'h0, 32'h0123_4567, 1'b0, 1'b0, 1'b0, 11'd1};
    vecs[3] = '{1'b0, 1'b1, 64'h0, 32'h89AB_CDEF, 1'b1, 1'b0, 1'b0, 11'd0};
    vecs[4] = '{1'b0, 1'b1, 64'h0, 32'h89AB_CDEF, 1'b1, 1'b0, 1'b0, 11'd0};
    vecs[5] = '{1'b1, 1'b0, 64'hCAFE_BABE_DEAD_BEEF, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0, 11'd2};
    vecs[6] = '{1'b0, 1'b1, 64'h0, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0, 11'd1};
    vecs[7] = '{1'b1, 1'b1, 64'h1111_2222_3333_4444, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 11'd2};
    vecs[8] = '{1'b0, 1'b1, 64'h0, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 11'd1};
    vecs[9] = '{1'b0, 1'b1, 64'h0, 32'h3333_4444, 1'b1, 1'b0, 1'b0, 11'd0};

    // Reset state
    do_reset();
    #1;
    check("reset.dout", 64'(bus.o_dout), 64'h0);
    check_flags("reset", 1'b1, 1'b0, 1'b0, 11'd0);

    // Vector table: basic ordering, read on empty, simultaneous read/write at cnt=1
    for (int i = 0; i < 10; i++) begin
      bus.i_wr_en = vecs[i].wr;
      bus.i_rd_en = vecs[i].rd;
      bus.i_din   = vecs[i].din;
      tick();
      check($sformatf("vec%0d.dout", i), 64'(bus.o_dout), 64'(vecs[i].dout));
      check_flags($sformatf("vec%0d", i), vecs[i].empty, vecs[i].full, vecs[i].pf,
                  vecs[i].count);
    end
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;

    // Programmable full rises only after the 512th beat
    do_reset();
    for (int i = 0; i < 512; i++) begin
      bus.i_wr_en = 1'b1;
      bus.i_din   = beat(1, i);
      tick();
      if (i == 510) check_flags("pf_511", 1'b0, 1'b0, 1'b0, 11'd1022);
    end
    bus.i_wr_en = 1'b0;
    check_flags("pf_512", 1'b0, 1'b0, 1'b1, 11'd1024);
    bus.i_rd_en = 1'b1;
    tick();
    bus.i_rd_en = 1'b0;
    check("pf_read.dout", 64'(bus.o_dout), 64'(beat(1, 0) >> 32));
    check_flags("pf_read", 1'b0, 1'b0, 1'b0, 11'd1023);

    // Fill completely, drop an extra write, then drain in order
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      bus.i_wr_en = 1'b1;
      bus.i_din   = beat(2, i);
      tick();
      if (i == 1022) check_flags("fill_1023", 1'b0, 1'b0, 1'b1, 11'd2046);
    end
    check_flags("fill_1024", 1'b0, 1'b1, 1'b1, 11'd2047);
    bus.i_din = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.i_wr_en = 1'b0;
    check_flags("fill_extra", 1'b0, 1'b1, 1'b1, 11'd2047);
    bus.i_rd_en = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      tick();
      b = beat(2, k >> 1);
      exp_word = (k % 2 == 0) ? b[63:32] : b[31:0];
      check($sformatf("drain%0d.dout", k), 64'(bus.o_dout), 64'(exp_word));
      if (k == 0) check_flags("drain_first", 1'b0, 1'b1, 1'b1, 11'd2047);
      if (k == 1) check_flags("drain_second", 1'b0, 1'b0, 1'b1, 11'd2046);
    end
    bus.i_rd_en = 1'b0;
    check_flags("drain_done", 1'b1, 1'b0, 1'b0, 11'd0);

    // Pointer wrap: three interleaved passes of 700 beats against a queue model
    do_reset();
    for (int pass = 0; pass < 3; pass++) begin
      int written;
      int cyc;
      logic wr, rd, rd_acc, wr_acc;
      written = 0;
      cyc = 0;
      while ((written < 700 || q.size() != 0) && cyc < 5000) begin
        wr = (written < 700) && (cyc % 2 == 0);
        rd = (cyc % 4 != 3);
        b  = beat(3 + pass, written);
        bus.i_wr_en = wr;
        bus.i_rd_en = rd;
        bus.i_din   = b;
        rd_acc = rd && (q.size() != 0);
        wr_acc = wr && (q.size() <= 2 * Depth - 2);
        if (rd_acc) exp_word = q.pop_front();
        if (wr_acc) begin
          q.push_back(b[63:32]);
          q.push_back(b[31:0]);
          written++;
        end
        tick();
        if (rd_acc) check($sformatf("wrap%0d_%0d.dout", pass, cyc), 64'(bus.o_dout),
                          64'(exp_word));
        check($sformatf("wrap%0d_%0d.count", pass, cyc), 64'(bus.o_rd_data_count),
              64'(q.size()));
        check($sformatf("wrap%0d_%0d.empty", pass, cyc), 64'(bus.o_empty),
              64'(q.size() == 0));
        check($sformatf("wrap%0d_%0d.full", pass, cyc), 64'(bus.o_full), 64'(1'b0));
        cyc++;
      end
      if (cyc >= 5000) begin
        n_checks++;
        $display("FAIL wrap%0d_budget: %0d words still queued, required 0", pass, q.size());
      end
    end
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    q.delete();

    // Asynchronous reset mid-stream at cnt=37
    do_reset();
    for (int i = 0; i < 19; i++) begin
      bus.i_wr_en = 1'b1;
      bus.i_din   = beat(9, i);
      tick();
    end
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b1;
    tick();
    bus.i_rd_en = 1'b0;
    check_flags("pre_rst", 1'b0, 1'b0, 1'b0, 11'd37);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.dout", 64'(bus.o_dout), 64'h0);
    check_flags("async_rst", 1'b1, 1'b0, 1'b0, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_wr_en = 1'b1;
    bus.i_din   = 64'h7777_6666_5555_4444;
    tick();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b1;
    tick();
    check("post_rst_hi.dout", 64'(bus.o_dout), 64'h7777_6666);
    check_flags("post_rst_hi", 1'b0, 1'b0, 1'b0, 11'd1);
    tick();
    bus.i_rd_en = 1'b0;
    check("post_rst_lo.dout", 64'(bus.o_dout), 64'h5555_4444);
    check_flags("post_rst_lo", 1'b1, 1'b0, 1'b0, 11'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
